// File: rtl/operand_sel_pkg.sv
// Shared types and helpers for operand slot selection.
// State codes, derived widths and the wrap-around slot scan.
package operand_sel_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_QUERY  = 2'd1;
    localparam state_t ST_BROWSE = 2'd2;
    localparam state_t ST_ERROR  = 2'd3;

    // Widest slot mask the scan supports.
    localparam int MASK_W = 15;

    function automatic int slot_bits_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int count_bits_f(input int n);
        return (n <= 1) ? 1 : $clog2(n + 1);
    endfunction

    // First set bit strictly above cur, wrapping at n; cur if none.
    // Starting from cur=n-1 yields the lowest set bit.
    function automatic int next_set_bit(
        input logic [MASK_W-1:0] mask,
        input int                cur,
        input int                n
    );
        int   idx;
        logic found;
        next_set_bit = cur;
        found        = 1'b0;
        for (int k = 1; k <= MASK_W; k++) begin
            if (k <= n) begin
                idx = cur + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && mask[4'(idx)]) begin
                    next_set_bit = idx;
                    found        = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/operand_select_ctrl.sv
// Runs a dimension query against storage search and lets the
// user browse the matching slots and confirm one as an operand.
module operand_select_ctrl
    import operand_sel_pkg::*;
#(
    parameter  int MAX_STORE       = 2,
    parameter  int ERR_HOLD_CYCLES = 100_000_000,
    localparam int SLOT_BITS       = slot_bits_f(MAX_STORE),
    localparam int COUNT_BITS      = count_bits_f(MAX_STORE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3:0]            req_m,
    input  logic [3:0]            req_n,
    input  logic                  btn_next,
    input  logic                  btn_confirm,
    input  logic                  btn_cancel,
    input  logic [MAX_STORE-1:0]  match_mask,
    input  logic [COUNT_BITS-1:0] match_count,
    output logic [3:0]            query_m,
    output logic [3:0]            query_n,
    output logic [SLOT_BITS-1:0]  cand_slot,
    output logic                  cand_valid,
    output logic [COUNT_BITS-1:0] cand_total,
    output logic [SLOT_BITS-1:0]  sel_slot,
    output logic                  sel_done,
    output logic                  sel_valid,
    output logic                  sel_fail,
    output logic                  busy
);

    localparam int ERR_W =
        (ERR_HOLD_CYCLES < 2) ? 1 : $clog2(ERR_HOLD_CYCLES);
    localparam logic [ERR_W-1:0] ERR_LOAD =
        ERR_W'(ERR_HOLD_CYCLES - 1);

    function automatic logic [SLOT_BITS-1:0] scan(
        input logic [MAX_STORE-1:0] mask,
        input logic [SLOT_BITS-1:0] cur
    );
        return SLOT_BITS'(next_set_bit(MASK_W'(mask), int'(cur), MAX_STORE));
    endfunction

    state_t                 state_q;
    state_t                 state_d;
    logic [MAX_STORE-1:0]   mask_q;
    logic [MAX_STORE-1:0]   mask_d;
    logic [ERR_W-1:0]       err_cnt_q;
    logic [ERR_W-1:0]       err_cnt_d;
    logic [3:0]             query_m_d;
    logic [3:0]             query_n_d;
    logic [SLOT_BITS-1:0]   cand_slot_d;
    logic [COUNT_BITS-1:0]  cand_total_d;
    logic [SLOT_BITS-1:0]   sel_slot_d;
    logic                   sel_valid_d;
    logic                   sel_done_d;
    logic                   cand_valid_d;
    logic                   busy_d;
    logic                   sel_fail_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            err_cnt_q  <= '0;
            query_m    <= '0;
            query_n    <= '0;
            cand_slot  <= '0;
            cand_total <= '0;
            sel_slot   <= '0;
            sel_valid  <= 1'b0;
            sel_done   <= 1'b0;
            cand_valid <= 1'b0;
            busy       <= 1'b0;
            sel_fail   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            err_cnt_q  <= err_cnt_d;
            query_m    <= query_m_d;
            query_n    <= query_n_d;
            cand_slot  <= cand_slot_d;
            cand_total <= cand_total_d;
            sel_slot   <= sel_slot_d;
            sel_valid  <= sel_valid_d;
            sel_done   <= sel_done_d;
            cand_valid <= cand_valid_d;
            busy       <= busy_d;
            sel_fail   <= sel_fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_QUERY;
                end
            end
            ST_QUERY: begin
                state_d = (match_count == '0) ? ST_ERROR : ST_BROWSE;
            end
            ST_BROWSE: begin
                if (btn_cancel || btn_confirm) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (btn_cancel || err_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mask_d       = mask_q;
        err_cnt_d    = err_cnt_q;
        query_m_d    = query_m;
        query_n_d    = query_n;
        cand_slot_d  = cand_slot;
        cand_total_d = cand_total;
        sel_slot_d   = sel_slot;
        sel_valid_d  = sel_valid;
        sel_done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    query_m_d   = req_m;
                    query_n_d   = req_n;
                    sel_valid_d = 1'b0;
                end
            end
            ST_QUERY: begin
                mask_d       = match_mask;
                cand_total_d = match_count;
                if (match_count == '0) begin
                    err_cnt_d = ERR_LOAD;
                end else begin
                    cand_slot_d = scan(match_mask, SLOT_BITS'(MAX_STORE - 1));
                end
            end
            ST_BROWSE: begin
                // Cancel beats confirm beats next.
                priority case (1'b1)
                    btn_cancel: ;
                    btn_confirm: begin
                        sel_slot_d  = cand_slot;
                        sel_valid_d = 1'b1;
                        sel_done_d  = 1'b1;
                    end
                    btn_next: cand_slot_d = scan(mask_q, cand_slot);
                    default: ;
                endcase
            end
            ST_ERROR: begin
                if (btn_cancel) begin
                    err_cnt_d = '0;
                end else if (err_cnt_q != '0) begin
                    err_cnt_d = err_cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
        cand_valid_d = (state_d == ST_BROWSE);
        busy_d       = (state_d == ST_QUERY) || (state_d == ST_BROWSE);
        sel_fail_d   = (state_d == ST_ERROR);
    end

endmodule

// File: tb/tb_operand_select_ctrl.sv
// Self-checking bench for operand_select_ctrl with a small
// behavioural storage search model and a confirm scoreboard.
module tb_operand_select_ctrl;

    localparam int MS = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] req_m;
    logic [3:0] req_n;
    logic       btn_next;
    logic       btn_confirm;
    logic       btn_cancel;
    logic [3:0] match_mask;
    logic [2:0] match_count;
    logic [3:0] query_m;
    logic [3:0] query_n;
    logic [1:0] cand_slot;
    logic       cand_valid;
    logic [2:0] cand_total;
    logic [1:0] sel_slot;
    logic       sel_done;
    logic       sel_valid;
    logic       sel_fail;
    logic       busy;

    int vectors = 0;
    int errors  = 0;
    int exp_q[$];
    int obs_q[$];

    logic       force_en = 1'b0;
    logic [3:0] force_mask = '0;
    logic [2:0] force_cnt = '0;

    // Slot dimensions held in storage: 2x3, 2x3, 3x3, 1x4.
    logic [3:0] slot_m [MS];
    logic [3:0] slot_n [MS];
    assign slot_m = '{4'd2, 4'd2, 4'd3, 4'd1};
    assign slot_n = '{4'd3, 4'd3, 4'd3, 4'd4};

    operand_select_ctrl #(
        .MAX_STORE       (MS),
        .ERR_HOLD_CYCLES (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .req_m       (req_m),
        .req_n       (req_n),
        .btn_next    (btn_next),
        .btn_confirm (btn_confirm),
        .btn_cancel  (btn_cancel),
        .match_mask  (match_mask),
        .match_count (match_count),
        .query_m     (query_m),
        .query_n     (query_n),
        .cand_slot   (cand_slot),
        .cand_valid  (cand_valid),
        .cand_total  (cand_total),
        .sel_slot    (sel_slot),
        .sel_done    (sel_done),
        .sel_valid   (sel_valid),
        .sel_fail    (sel_fail),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        match_mask  = '0;
        match_count = '0;
        for (int i = 0; i < MS; i++) begin
            if (slot_m[i] == query_m && slot_n[i] == query_n) begin
                match_mask[i] = 1'b1;
                match_count   = match_count + 3'd1;
            end
        end
        if (force_en) begin
            match_mask  = force_mask;
            match_count = force_cnt;
        end
    end

    always @(negedge clk) begin
        if (sel_done) obs_q.push_back(int'(sel_slot));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] m, input logic [3:0] n);
        req_m = m;
        req_n = n;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) step();
        vectors++;
        if ({query_m, query_n, cand_slot, cand_valid, cand_total, sel_slot,
             sel_done, sel_valid, sel_fail, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outs: got busy=%0d fail=%0d qm=%0d want all 0",
                     busy, sel_fail, query_m);
        end
        // start during reset must be ignored
        start = 1'b1;
        req_m = 4'd2;
        req_n = 4'd3;
        step();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0 || query_m !== 4'd0) begin
            errors++;
            $display("FAIL reset_start: busy=%0d qm=%0d want 0 0", busy, query_m);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_two_match();
        do_start(4'd2, 4'd3);
        vectors++;
        if (query_m !== 4'd2 || query_n !== 4'd3 || busy !== 1'b1 || cand_valid !== 1'b0) begin
            errors++;
            $display("FAIL query_lat: qm=%0d qn=%0d busy=%0d cv=%0d want 2 3 1 0",
                     query_m, query_n, busy, cand_valid);
        end
        step();
        vectors++;
        if (cand_valid !== 1'b1 || cand_slot !== 2'd0 || cand_total !== 3'd2) begin
            errors++;
            $display("FAIL browse_entry: cv=%0d slot=%0d total=%0d want 1 0 2",
                     cand_valid, cand_slot, cand_total);
        end
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        vectors++;
        if (cand_slot !== 2'd1) begin
            errors++;
            $display("FAIL next_1: slot=%0d want 1", cand_slot);
        end
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        vectors++;
        if (cand_slot !== 2'd0) begin
            errors++;
            $display("FAIL next_wrap: slot=%0d want 0", cand_slot);
        end
        exp_q.push_back(0);
        btn_confirm = 1'b1;
        step();
        btn_confirm = 1'b0;
        vectors++;
        if (sel_done !== 1'b1 || sel_slot !== 2'd0 || sel_valid !== 1'b1 ||
            busy !== 1'b0 || cand_valid !== 1'b0) begin
            errors++;
            $display("FAIL confirm: done=%0d slot=%0d valid=%0d busy=%0d cv=%0d want 1 0 1 0 0",
                     sel_done, sel_slot, sel_valid, busy, cand_valid);
        end
        step();
        vectors++;
        if (sel_done !== 1'b0 || sel_valid !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: done=%0d valid=%0d want 0 1", sel_done, sel_valid);
        end
    endtask

    task automatic test_single_match();
        do_start(4'd3, 4'd3);
        vectors++;
        if (sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_clears: valid=%0d want 0", sel_valid);
        end
        step();
        vectors++;
        if (cand_slot !== 2'd2 || cand_total !== 3'd1) begin
            errors++;
            $display("FAIL single_entry: slot=%0d total=%0d want 2 1", cand_slot, cand_total);
        end
        for (int i = 0; i < 2; i++) begin
            btn_next = 1'b1;
            step();
            btn_next = 1'b0;
            vectors++;
            if (cand_slot !== 2'd2) begin
                errors++;
                $display("FAIL single_next%0d: slot=%0d want 2", i, cand_slot);
            end
        end
        exp_q.push_back(2);
        btn_confirm = 1'b1;
        step();
        btn_confirm = 1'b0;
        vectors++;
        if (sel_slot !== 2'd2 || sel_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_confirm: slot=%0d valid=%0d want 2 1", sel_slot, sel_valid);
        end
        step();
    endtask

    task automatic test_no_match();
        int hi;
        do_start(4'd4, 4'd4);
        step();
        vectors++;
        if (sel_fail !== 1'b1 || busy !== 1'b0 || cand_total !== 3'd0) begin
            errors++;
            $display("FAIL err_entry: fail=%0d busy=%0d total=%0d want 1 0 0",
                     sel_fail, busy, cand_total);
        end
        hi = 1;
        for (int i = 0; i < 20; i++) begin
            if (i == 1) begin
                req_m = 4'd2;
                req_n = 4'd3;
                start = 1'b1;
                btn_next = 1'b1;
                btn_confirm = 1'b1;
            end
            step();
            start = 1'b0;
            btn_next = 1'b0;
            btn_confirm = 1'b0;
            if (sel_fail) hi++;
            else break;
        end
        vectors++;
        if (hi !== 5) begin
            errors++;
            $display("FAIL err_hold: cycles=%0d want 5", hi);
        end
        vectors++;
        if (busy !== 1'b0 || query_m !== 4'd4 || sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_ignore: busy=%0d qm=%0d valid=%0d want 0 4 0",
                     busy, query_m, sel_valid);
        end
        step();
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL err_idle: busy=%0d want 0", busy);
        end
    endtask

    task automatic test_error_cancel();
        do_start(4'd4, 4'd4);
        step();
        btn_cancel = 1'b1;
        step();
        btn_cancel = 1'b0;
        vectors++;
        if (sel_fail !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_cancel: fail=%0d busy=%0d want 0 0", sel_fail, busy);
        end
    endtask

    task automatic test_simultaneous();
        do_start(4'd2, 4'd3);
        step();
        exp_q.push_back(0);
        btn_next = 1'b1;
        btn_confirm = 1'b1;
        step();
        btn_next = 1'b0;
        btn_confirm = 1'b0;
        vectors++;
        if (sel_done !== 1'b1 || sel_slot !== 2'd0) begin
            errors++;
            $display("FAIL next_confirm: done=%0d slot=%0d want 1 0", sel_done, sel_slot);
        end
        step();
        do_start(4'd2, 4'd3);
        step();
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        btn_cancel = 1'b1;
        btn_confirm = 1'b1;
        step();
        btn_cancel = 1'b0;
        btn_confirm = 1'b0;
        vectors++;
        if (sel_valid !== 1'b0 || sel_done !== 1'b0 || busy !== 1'b0 || cand_valid !== 1'b0) begin
            errors++;
            $display("FAIL cancel_confirm: valid=%0d done=%0d busy=%0d cv=%0d want 0 0 0 0",
                     sel_valid, sel_done, busy, cand_valid);
        end
        step();
    endtask

    task automatic test_mask_change();
        do_start(4'd2, 4'd3);
        step();
        force_mask = 4'b0001;
        force_cnt = 3'd1;
        force_en = 1'b1;
        step();
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        vectors++;
        if (cand_slot !== 2'd1 || cand_total !== 3'd2) begin
            errors++;
            $display("FAIL mask_hold: slot=%0d total=%0d want 1 2", cand_slot, cand_total);
        end
        btn_cancel = 1'b1;
        step();
        btn_cancel = 1'b0;
        force_en = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        do_start(4'd2, 4'd3);
        step();
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({query_m, query_n, cand_slot, cand_valid, cand_total, sel_slot,
             sel_done, sel_valid, sel_fail, busy} !== '0) begin
            errors++;
            $display("FAIL async_reset: cv=%0d busy=%0d qm=%0d total=%0d want all 0",
                     cand_valid, busy, query_m, cand_total);
        end
        #2 rst = 1'b1;
        step();
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%0d want 0", busy);
        end
    endtask

    task automatic test_scoreboard();
        int e;
        int o;
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL sb_count: sel_done pulses=%0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL sb_slot: sel_slot=%0d want %0d", o, e);
            end
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: bench timed out");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        start = 1'b0;
        req_m = '0;
        req_n = '0;
        btn_next = 1'b0;
        btn_confirm = 1'b0;
        btn_cancel = 1'b0;
        test_reset();
        test_two_match();
        test_single_match();
        test_no_match();
        test_error_cancel();
        test_simultaneous();
        test_mask_change();
        test_async_reset();
        test_scoreboard();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
